// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the Xosera register bus initiator.
// Holds bus polarity constants, common data types, the initiator FSM
// state type and a small helper used to size counters.
package bus_initiator_pkg;

  localparam logic CS_ENABLED  = 1'b0;
  localparam logic CS_DISABLED = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;
  localparam logic RnW_READ    = 1'b1;
  localparam logic DTACK_ACK   = 1'b0;
  localparam logic DTACK_NAK   = 1'b1;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] reg_num_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } initiator_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshake plus Xosera register bus signals.
//   master : view of the initiator (drives req_ready, rsp_*, bus_* outputs)
//   slave  : view of the requester/bus target (drives req_*, bus_data_i, bus_dtack_i)
// bus_dtack_i only exists when BUS_INITIATOR_DTACK_EN is defined.
interface bus_initiator_if;
  import bus_initiator_pkg::*;

  logic     req_valid_i;
  logic     req_ready_o;
  logic     req_rd_nwr_i;
  reg_num_t req_reg_num_i;
  logic     req_bytesel_i;
  byte_t    req_data_i;
  logic     rsp_valid_o;
  byte_t    rsp_data_o;
  logic     rsp_timeout_o;
  logic     bus_cs_n_o;
  logic     bus_rd_nwr_o;
  logic     bus_bytesel_o;
  reg_num_t bus_reg_num_o;
  byte_t    bus_data_o;
  logic     bus_data_oe_o;
  byte_t    bus_data_i;
`ifdef BUS_INITIATOR_DTACK_EN
  logic     bus_dtack_i;
`endif

  modport master (
    input  req_valid_i, req_rd_nwr_i, req_reg_num_i, req_bytesel_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
    output bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o,
    output bus_data_o, bus_data_oe_o,
`ifdef BUS_INITIATOR_DTACK_EN
    input  bus_dtack_i,
`endif
    input  bus_data_i
  );

  modport slave (
    output req_valid_i, req_rd_nwr_i, req_reg_num_i, req_bytesel_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
    input  bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o,
    input  bus_data_o, bus_data_oe_o,
`ifdef BUS_INITIATOR_DTACK_EN
    output bus_dtack_i,
`endif
    output bus_data_i
  );

endinterface

// File: rtl/bus_initiator_sync.sv
// Generic 1-bit two-flop synchronizer with parameterized reset value.
//   clk      in  destination clock
//   reset_i  in  synchronous active-high reset
//   d_i      in  asynchronous input
//   q_o      out synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      q_o    <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/bus_initiator.sv
// Host-side master for the Xosera 8-bit register bus.
// Turns single-beat register read/write requests into CS/RnW/reg/bytesel/data
// bus cycles with programmable setup, strobe, hold and recovery timing, and
// returns a one-cycle response pulse.
//   clk      in  system clock
//   reset_i  in  synchronous active-high reset
//   bif      master modport of bus_initiator_if (request, response, bus pins)
// Optional: BUS_INITIATOR_DTACK_EN enables DTACK wait with timeout; without it
// CS is held for exactly STROBE_CYCLES and rsp_timeout_o stays 0.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned RECOVERY_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned STROBE_CYCLES   = 8
) (
  input logic            clk,
  input logic            reset_i,
  bus_initiator_if.master bif
);

  localparam int unsigned CNT_MAX = max2(max2(max2(SETUP_CYCLES, HOLD_CYCLES),
                                              max2(RECOVERY_CYCLES, TIMEOUT_CYCLES)),
                                         STROBE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  initiator_state_t state_q, state_d;
  cnt_t     cnt_q, cnt_d, cnt_inc;
  logic     ready_q, ready_d;
  logic     rsp_valid_q, rsp_valid_d;
  byte_t    rsp_data_q, rsp_data_d;
  logic     rsp_timeout_q, rsp_timeout_d;
  logic     cs_n_q, cs_n_d;
  logic     rd_nwr_q, rd_nwr_d;
  logic     bytesel_q, bytesel_d;
  reg_num_t reg_num_q, reg_num_d;
  byte_t    data_q, data_d;
  logic     oe_q, oe_d;

  logic strobe_done;     // strobe ended normally (ACK or fixed width reached)
  logic strobe_timeout;  // strobe ended without ACK
  logic recover_ok;      // DTACK condition for leaving RECOVER

`ifdef BUS_INITIATOR_DTACK_EN
  logic dtack_sync;

  sync_2ff #(.RESET_VAL(DTACK_NAK)) u_dtack_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .d_i     (bif.bus_dtack_i),
    .q_o     (dtack_sync)
  );

  assign strobe_done    = (dtack_sync == DTACK_ACK);
  assign strobe_timeout = (cnt_q == cnt_t'(TIMEOUT_CYCLES - 1));
  // After a timeout the target may never release DTACK, so don't wait on it.
  assign recover_ok     = (dtack_sync == DTACK_NAK) || rsp_timeout_q;
`else
  assign strobe_done    = (cnt_q == cnt_t'(STROBE_CYCLES - 1));
  assign strobe_timeout = 1'b0;
  assign recover_ok     = 1'b1;
`endif

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_inc;
    ready_d       = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cs_n_d        = cs_n_q;
    rd_nwr_d      = rd_nwr_q;
    bytesel_d     = bytesel_q;
    reg_num_d     = reg_num_q;
    data_d        = data_q;
    oe_d          = oe_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        if (bif.req_valid_i && ready_q) begin
          ready_d   = 1'b0;
          rd_nwr_d  = bif.req_rd_nwr_i;
          bytesel_d = bif.req_bytesel_i;
          reg_num_d = bif.req_reg_num_i;
          data_d    = bif.req_data_i;
          oe_d      = (bif.req_rd_nwr_i == RnW_WRITE);
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == cnt_t'(SETUP_CYCLES)) begin
          cs_n_d  = CS_ENABLED;
          cnt_d   = '0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (strobe_done || strobe_timeout) begin
          cs_n_d        = CS_DISABLED;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = !strobe_done;
          rsp_data_d    = (strobe_done && rd_nwr_q == RnW_READ) ? bif.bus_data_i : '0;
          cnt_d         = '0;
          state_d       = HOLD;
        end
      end
      // cnt keeps running through HOLD into RECOVER so recovery is measured
      // from the CS deassert edge rather than from the end of HOLD.
      HOLD: begin
        if (cnt_q >= cnt_t'(HOLD_CYCLES - 1)) begin
          oe_d    = 1'b0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (cnt_q >= cnt_t'(RECOVERY_CYCLES - 1) && recover_ok) begin
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cs_n_d  = CS_DISABLED;
        oe_d    = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cs_n_q        <= CS_DISABLED;
      rd_nwr_q      <= RnW_READ;
      bytesel_q     <= 1'b0;
      reg_num_q     <= '0;
      data_q        <= '0;
      oe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cs_n_q        <= cs_n_d;
      rd_nwr_q      <= rd_nwr_d;
      bytesel_q     <= bytesel_d;
      reg_num_q     <= reg_num_d;
      data_q        <= data_d;
      oe_q          <= oe_d;
    end
  end

  assign bif.req_ready_o   = ready_q;
  assign bif.rsp_valid_o   = rsp_valid_q;
  assign bif.rsp_data_o    = rsp_data_q;
  assign bif.rsp_timeout_o = rsp_timeout_q;
  assign bif.bus_cs_n_o    = cs_n_q;
  assign bif.bus_rd_nwr_o  = rd_nwr_q;
  assign bif.bus_bytesel_o = bytesel_q;
  assign bif.bus_reg_num_o = reg_num_q;
  assign bif.bus_data_o    = data_q;
  assign bif.bus_data_oe_o = oe_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed self-checking bench for bus_initiator (default parameters).
module tb_bus_initiator;
  import bus_initiator_pkg::*;

  localparam byte_t RD_RESP = 8'h5A;

  logic        clk;
  logic        reset_i;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n;
  int unsigned exp_wr   = 0;
  logic        oe_seen;

  bus_initiator_if bif();

  bus_initiator #(
    .SETUP_CYCLES    (2),
    .HOLD_CYCLES     (2),
    .RECOVERY_CYCLES (4),
    .TIMEOUT_CYCLES  (64),
    .STROBE_CYCLES   (8)
  ) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bif     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus target: returns RD_RESP while a read strobe is active.
  always_comb begin
    bif.bus_data_i = 8'h00;
    if (bif.bus_cs_n_o == CS_ENABLED && bif.bus_rd_nwr_o == RnW_READ)
      bif.bus_data_i = RD_RESP;
  end

  // Target write-strobe monitor: one event per CS falling edge on a write.
  logic        cs_prev = 1'b1;
  int unsigned wr_count = 0;
  reg_num_t    wr_reg = '0;
  byte_t       wr_data = '0;
  logic        wr_bsel = 1'b0;
  always @(negedge clk) begin
    if (cs_prev == CS_DISABLED && bif.bus_cs_n_o == CS_ENABLED &&
        bif.bus_rd_nwr_o == RnW_WRITE) begin
      wr_count++;
      wr_reg  = bif.bus_reg_num_o;
      wr_data = bif.bus_data_o;
      wr_bsel = bif.bus_bytesel_o;
    end
    cs_prev = bif.bus_cs_n_o;
  end

`ifdef BUS_INITIATOR_DTACK_EN
  // Responder: ACK after 6 CS-low cycles (gives the same 8-cycle strobe as
  // the fixed-width build once the 2-FF synchronizer is included), then keeps
  // ACK for hold_len cycles after CS release.
  logic        ack_en   = 1'b1;
  int unsigned hold_len = 0;
  int unsigned lo_cnt   = 0;
  int unsigned hi_cnt   = 0;
  always @(negedge clk) begin
    if (bif.bus_cs_n_o == CS_ENABLED) begin
      lo_cnt++;
      hi_cnt = 0;
      bif.bus_dtack_i = (ack_en && lo_cnt >= 6) ? DTACK_ACK : DTACK_NAK;
    end else begin
      hi_cnt++;
      lo_cnt = 0;
      bif.bus_dtack_i = (bif.bus_dtack_i == DTACK_ACK && hi_cnt <= hold_len) ?
                        DTACK_ACK : DTACK_NAK;
    end
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag, input int unsigned bound);
    checks++;
    failures++;
    $error("FAIL %s observed=no_event expected=event_within_%0d_cycles", tag, bound);
  endtask

  task automatic step(input int unsigned k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_cs(input string tag, input logic lvl, input int unsigned bound,
                         output int unsigned cnt);
    cnt = 0;
    while (bif.bus_cs_n_o !== lvl && cnt < bound) begin
      step(1);
      cnt++;
    end
    if (bif.bus_cs_n_o !== lvl) bound_fail(tag, bound);
  endtask

  task automatic wait_ready(input string tag, input int unsigned bound, output int unsigned cnt);
    cnt = 0;
    while (bif.req_ready_o !== 1'b1 && cnt < bound) begin
      step(1);
      cnt++;
    end
    if (bif.req_ready_o !== 1'b1) bound_fail(tag, bound);
  endtask

  task automatic wait_rsp(input string tag, input int unsigned bound, output int unsigned cnt,
                          output logic oe_any);
    cnt    = 0;
    oe_any = 1'b0;
    while (bif.rsp_valid_o !== 1'b1 && cnt < bound) begin
      oe_any = oe_any | bif.bus_data_oe_o;
      step(1);
      cnt++;
    end
    if (bif.rsp_valid_o !== 1'b1) bound_fail(tag, bound);
  endtask

  task automatic issue(input logic rd, input reg_num_t r, input logic bs, input byte_t d);
    bif.req_valid_i   = 1'b1;
    bif.req_rd_nwr_i  = rd;
    bif.req_reg_num_i = r;
    bif.req_bytesel_i = bs;
    bif.req_data_i    = d;
  endtask

  initial begin
    reset_i           = 1'b1;
    bif.req_valid_i   = 1'b0;
    bif.req_rd_nwr_i  = 1'b0;
    bif.req_reg_num_i = '0;
    bif.req_bytesel_i = 1'b0;
    bif.req_data_i    = '0;
    step(3);

    // Reset state
    chk("rst_cs", bif.bus_cs_n_o, CS_DISABLED);
    chk("rst_rnw", bif.bus_rd_nwr_o, RnW_READ);
    chk("rst_oe", bif.bus_data_oe_o, 0);
    chk("rst_rsp_valid", bif.rsp_valid_o, 0);
    chk("rst_ready", bif.req_ready_o, 0);
    chk("rst_rsp_data", bif.rsp_data_o, 0);
    chk("rst_timeout", bif.rsp_timeout_o, 0);
    chk("rst_reg", bif.bus_reg_num_o, 0);
    reset_i = 1'b0;
    step(1);
    chk("rst_ready_after", bif.req_ready_o, 1);

    // Write reg 3, odd byte, 0xA5: cycle-by-cycle timing
    issue(RnW_WRITE, 4'h3, 1'b1, 8'hA5);
    exp_wr++;
    step(1);
    bif.req_valid_i = 1'b0;
    chk("wr_ready_low", bif.req_ready_o, 0);
    chk("wr_reg", bif.bus_reg_num_o, 4'h3);
    chk("wr_bsel", bif.bus_bytesel_o, 1);
    chk("wr_data", bif.bus_data_o, 8'hA5);
    chk("wr_oe", bif.bus_data_oe_o, 1);
    chk("wr_rnw", bif.bus_rd_nwr_o, RnW_WRITE);
    chk("wr_cs_setup0", bif.bus_cs_n_o, CS_DISABLED);
    step(2);
    chk("wr_cs_setup2", bif.bus_cs_n_o, CS_DISABLED);
    chk("wr_oe_setup2", bif.bus_data_oe_o, 1);
    step(1);
    chk("wr_cs_on", bif.bus_cs_n_o, CS_ENABLED);
    step(7);
    chk("wr_cs_last", bif.bus_cs_n_o, CS_ENABLED);
    chk("wr_rsp_early", bif.rsp_valid_o, 0);
    step(1);
    chk("wr_cs_off", bif.bus_cs_n_o, CS_DISABLED);
    chk("wr_rsp_valid", bif.rsp_valid_o, 1);
    chk("wr_rsp_timeout", bif.rsp_timeout_o, 0);
    chk("wr_rsp_data", bif.rsp_data_o, 8'h00);
    chk("wr_hold0_data", bif.bus_data_o, 8'hA5);
    step(1);
    chk("wr_rsp_pulse", bif.rsp_valid_o, 0);
    chk("wr_hold1_oe", bif.bus_data_oe_o, 1);
    chk("wr_hold1_data", bif.bus_data_o, 8'hA5);
    step(1);
    chk("wr_hold_end_oe", bif.bus_data_oe_o, 0);
    step(1);
    chk("wr_recover_ready", bif.req_ready_o, 0);
    step(1);
    chk("wr_idle_ready", bif.req_ready_o, 1);
    chk("wr_strobes", wr_count, exp_wr);
    chk("wr_mon_reg", wr_reg, 4'h3);
    chk("wr_mon_data", wr_data, 8'hA5);
    chk("wr_mon_bsel", wr_bsel, 1);

    // Read reg 0xC
    issue(RnW_READ, 4'hC, 1'b0, 8'hFF);
    step(1);
    bif.req_valid_i = 1'b0;
    chk("rd_reg", bif.bus_reg_num_o, 4'hC);
    chk("rd_rnw", bif.bus_rd_nwr_o, RnW_READ);
    wait_rsp("rd_rsp_wait", 40, n, oe_seen);
    chk("rd_latency", n, 11);
    chk("rd_data", bif.rsp_data_o, RD_RESP);
    chk("rd_timeout", bif.rsp_timeout_o, 0);
    chk("rd_oe_never", oe_seen | bif.bus_data_oe_o, 0);
    wait_ready("rd_ready_wait", 20, n);
    chk("rd_recovery", n, 4);

`ifdef BUS_INITIATOR_DTACK_EN
    // No ACK: 64-cycle strobe then timeout
    ack_en = 1'b0;
    issue(RnW_READ, 4'h2, 1'b0, 8'h00);
    step(1);
    bif.req_valid_i = 1'b0;
    wait_cs("to_cs_on_wait", CS_ENABLED, 10, n);
    chk("to_setup", n, 3);
    wait_cs("to_cs_off_wait", CS_DISABLED, 100, n);
    chk("to_cs_width", n, 64);
    chk("to_rsp_valid", bif.rsp_valid_o, 1);
    chk("to_flag", bif.rsp_timeout_o, 1);
    chk("to_data", bif.rsp_data_o, 8'h00);
    wait_ready("to_ready_wait", 20, n);
    chk("to_recovery", n, 4);
    ack_en = 1'b1;

    // DTACK held 10 cycles after release, back-to-back writes
    hold_len = 10;
    issue(RnW_WRITE, 4'h6, 1'b0, 8'h33);
    exp_wr += 2;
    step(1);
    bif.req_data_i = 8'h44;
    wait_cs("hd_cs_on_wait", CS_ENABLED, 10, n);
    wait_cs("hd_cs_off_wait", CS_DISABLED, 40, n);
    wait_cs("hd_cs_on2_wait", CS_ENABLED, 60, n);
    chk("hd_cs_gap", n, 17);
    hold_len = 0;
    bif.req_valid_i = 1'b0;
    chk("hd_data2", bif.bus_data_o, 8'h44);
    wait_cs("hd_cs_off2_wait", CS_DISABLED, 40, n);
    chk("hd_timeout_clr", bif.rsp_timeout_o, 0);
    wait_ready("hd_ready_wait", 40, n);
`endif

    // Back-to-back writes with req_valid_i held high
    issue(RnW_WRITE, 4'h5, 1'b0, 8'h11);
    exp_wr += 2;
    step(1);
    bif.req_data_i = 8'h22;
    wait_cs("bb_cs_on_wait", CS_ENABLED, 10, n);
    chk("bb_setup", n, 3);
    wait_cs("bb_cs_off_wait", CS_DISABLED, 40, n);
    wait_cs("bb_cs_on2_wait", CS_ENABLED, 40, n);
    chk("bb_cs_gap", n, 8);
    bif.req_valid_i = 1'b0;
    chk("bb_data2", bif.bus_data_o, 8'h22);
    chk("bb_reg2", bif.bus_reg_num_o, 4'h5);
    wait_cs("bb_cs_off2_wait", CS_DISABLED, 40, n);
    wait_ready("bb_ready_wait", 40, n);
    chk("bb_strobes", wr_count, exp_wr);
    chk("bb_mon_data", wr_data, 8'h22);

    // Reset asserted during STROBE
    issue(RnW_WRITE, 4'h9, 1'b1, 8'h3C);
    exp_wr++;
    step(1);
    bif.req_valid_i = 1'b0;
    wait_cs("mr_cs_on_wait", CS_ENABLED, 10, n);
    step(2);
    reset_i = 1'b1;
    step(1);
    chk("mr_cs", bif.bus_cs_n_o, CS_DISABLED);
    chk("mr_oe", bif.bus_data_oe_o, 0);
    chk("mr_rsp_valid", bif.rsp_valid_o, 0);
    chk("mr_ready", bif.req_ready_o, 0);
    reset_i = 1'b0;
    step(1);
    chk("mr_ready_after", bif.req_ready_o, 1);
    chk("mr_rsp_valid_after", bif.rsp_valid_o, 0);
    step(10);
    chk("mr_idle_cs", bif.bus_cs_n_o, CS_DISABLED);
    chk("mr_idle_rsp", bif.rsp_valid_o, 0);
    chk("final_strobes", wr_count, exp_wr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
